instruction_fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V pipeline: owns the program counter, drives the instruction cache address, and loads the IF/ID pipeline register with the returned instruction. It sits directly upstream of the instruction cache, which it drives, and directly upstream of decode, which it feeds. It absorbs cache misses (`icache_busywait`), hazard stalls and branch redirects. It never changes the cache address while a miss is in progress.

---
 rtl/instruction_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage of the RISC-V pipeline. It owns the program counter, drives
//   the instruction cache address and loads the IF/ID pipeline register.
//   Cache misses, hazard stalls and branch redirects are absorbed here.
//   The cache address is never changed while a miss is in progress.
//
// Ports
//   clock              in   rising-edge clock
//   reset              in   synchronous, active-low reset
//   icache_address     out  fetch address (the PC register itself)
//   icache_instruction in   instruction word, valid when icache_busywait=0
//   icache_busywait    in   cache miss in progress
//   stall              in   hazard request to hold PC and IF/ID
//   branch_taken       in   redirect request from execute (flushes IF/ID)
//   branch_target      in   redirect address, bits [1:0] ignored
//   ifid_pc            out  PC of the instruction held in IF/ID
//   ifid_instruction   out  instruction held in IF/ID
//   ifid_valid         out  IF/ID holds a real instruction (0 = bubble)
//   miss_cycles        out  saturating count of edges with busywait=1
//
// Handshake: the cache has no valid/ready pair. A word is accepted on a
// rising edge only when icache_busywait=0 at that edge; while busywait=1
// the address stays constant so the cache can finish the fill.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int          MISS_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [31:0]           icache_address,
  input  logic [31:0]           icache_instruction,
  input  logic                  icache_busywait,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  output logic [31:0]           ifid_pc,
  output logic [31:0]           ifid_instruction,
  output logic                  ifid_valid,
  output logic [MISS_CNT_W-1:0] miss_cycles
);

  // RUN: normal fetching. KILL: a redirect arrived during a miss; the line
  // being filled belongs to the wrong path and its word is discarded.
  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_target;
  logic [31:0] target_aligned;

  localparam logic [MISS_CNT_W-1:0] CNT_MAX = {MISS_CNT_W{1'b1}};
  localparam logic [MISS_CNT_W-1:0] CNT_ONE = {{(MISS_CNT_W-1){1'b0}}, 1'b1};

  assign target_aligned = branch_target & ~32'h0000_0003;
  assign icache_address = pc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= RUN;
      pc               <= RESET_PC;
      pending_target   <= 32'h0;
      ifid_pc          <= 32'h0;
      ifid_instruction <= NOP_INSTR;
      ifid_valid       <= 1'b0;
      miss_cycles      <= '0;
    end else begin
      if (icache_busywait && (miss_cycles != CNT_MAX)) begin
        miss_cycles <= miss_cycles + CNT_ONE;
      end

      case (state)
        RUN: begin
          if (!icache_busywait) begin
            if (branch_taken) begin
              pc               <= target_aligned;
              ifid_instruction <= NOP_INSTR;
              ifid_valid       <= 1'b0;
            end else if (!stall) begin
              ifid_pc          <= pc;
              ifid_instruction <= icache_instruction;
              ifid_valid       <= 1'b1;
              pc               <= pc + 32'd4;
            end
          end else begin
            // Miss: pc is frozen. A redirect is parked until the fill ends.
            if (branch_taken) begin
              pending_target   <= target_aligned;
              ifid_instruction <= NOP_INSTR;
              ifid_valid       <= 1'b0;
              state            <= KILL;
            end else if (!stall) begin
              ifid_instruction <= NOP_INSTR;
              ifid_valid       <= 1'b0;
            end
          end
        end

        KILL: begin
          if (!icache_busywait) begin
            // Fill done: drop its word and jump; a same-cycle redirect wins.
            pc               <= branch_taken ? target_aligned : pending_target;
            ifid_instruction <= NOP_INSTR;
            ifid_valid       <= 1'b0;
            state            <= RUN;
          end else begin
            if (branch_taken) begin
              pending_target <= target_aligned;
            end
            if (branch_taken || !stall) begin
              ifid_instruction <= NOP_INSTR;
              ifid_valid       <= 1'b0;
            end
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        busy;
  logic        stall;
  logic        br;
  logic [31:0] tgt;

  always #5 clock = ~clock;

  logic [31:0] addr, ipc, iins;
  logic        ival;
  logic [15:0] miss16;
  logic [31:0] addr4, ipc4, iins4;
  logic        ival4;
  logic [3:0]  miss4;

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .icache_address(addr),
    .icache_instruction(instr), .icache_busywait(busy), .stall(stall),
    .branch_taken(br), .branch_target(tgt), .ifid_pc(ipc),
    .ifid_instruction(iins), .ifid_valid(ival), .miss_cycles(miss16)
  );

  instruction_fetch_unit #(.MISS_CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .icache_address(addr4),
    .icache_instruction(instr), .icache_busywait(busy), .stall(stall),
    .branch_taken(br), .branch_target(tgt), .ifid_pc(ipc4),
    .ifid_instruction(iins4), .ifid_valid(ival4), .miss_cycles(miss4)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Expressed as pipeline rules: a fetch "completes" only on a hit with no
  // redirect, stall or outstanding wrong-path fill; a redirect seen during a
  // miss is remembered (latest wins) and applied when the fill ends.
  logic [31:0] m_pc, m_pend, m_ipc, m_iins;
  bit          m_ival, m_wrong_path;
  int          m_miss;
  logic [31:0] exp_q[$];   // delivered instruction PCs in order

  always @(posedge clock) begin
    logic [31:0] t;
    bit deliver, hold;
    if (!reset) begin
      m_pc = 32'h0; m_pend = 32'h0; m_ipc = 32'h0; m_iins = NOP;
      m_ival = 0; m_wrong_path = 0; m_miss = 0;
    end else begin
      t = {tgt[31:2], 2'b00};
      if (busy) m_miss++;
      deliver = !busy && !m_wrong_path && !br && !stall;
      hold    = stall && !br && !(m_wrong_path && !busy) && !deliver;
      if (deliver) begin
        m_ipc = m_pc; m_iins = instr; m_ival = 1;
        exp_q.push_back(m_pc);
      end else if (!hold) begin
        m_iins = NOP; m_ival = 0;
      end
      if (!busy) begin
        if (m_wrong_path) m_pc = br ? t : m_pend;
        else if (br)      m_pc = t;
        else if (deliver) m_pc = m_pc + 32'd4;
        m_wrong_path = 0;
      end else if (br) begin
        m_pend = t;
        m_wrong_path = 1;
      end
    end
  end

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("addr", addr, m_pc);
      check("addr_w4", addr4, m_pc);
      check("ifid_valid", {31'b0, ival}, {31'b0, m_ival});
      check("ifid_instr", iins, m_iins);
      if (m_ival) check("ifid_pc", ipc, m_ipc);
      check("miss16", {16'b0, miss16}, (m_miss > 65535) ? 32'hFFFF : 32'(m_miss));
      check("miss4", {28'b0, miss4}, (m_miss > 15) ? 32'hF : 32'(m_miss));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit b, input logic [31:0] ins, input bit s,
                     input bit bt, input logic [31:0] t);
    busy = b; instr = ins; stall = s; br = bt; tgt = t;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h1000_0000 + 32'(i), 0, 0, 32'h0);
  endtask

  // ---------------- directed sequence + random phase ----------------
  initial begin
    reset = 1'b0; busy = 0; stall = 0; br = 0; tgt = 0; instr = 0;
    cyc(0, 32'h0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 32'h0, 0, 0, 0);
    // Reset values (literal pins)
    check("rst_addr", addr, 32'h0);
    check("rst_valid", {31'b0, ival}, 32'h0);
    check("rst_instr", iins, NOP);
    check("rst_ifid_pc", ipc, 32'h0);
    check("rst_miss", {16'b0, miss16}, 32'h0);

    reset = 1'b1;
    cyc(0, 32'hAAAA_0001, 0, 0, 0);
    check("hit0_addr", addr, 32'h4);
    check("hit0_pc", ipc, 32'h0);
    check("hit0_instr", iins, 32'hAAAA_0001);
    cyc(0, 32'hAAAA_0002, 0, 0, 0);
    check("hit1_addr", addr, 32'h8);
    check("hit1_pc", ipc, 32'h4);
    run(2);
    check("pre_miss_addr", addr, 32'h10);

    // Miss at 0x10 for 5 edges
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'hABCD_0123, 0, 0, 0);
      check("miss_addr_held", addr, 32'h10);
      check("miss_bubble", {31'b0, ival}, 32'h0);
    end
    cyc(0, 32'hABCD_0123, 0, 0, 0);
    check("miss_done_pc", ipc, 32'h10);
    check("miss_done_instr", iins, 32'hABCD_0123);
    check("miss_done_valid", {31'b0, ival}, 32'h1);
    check("miss_done_addr", addr, 32'h14);
    check("miss_count", {16'b0, miss16}, 32'd5);

    // Stall holds, then branch beats stall
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h5555_5555, 1, 0, 0);
      check("stall_addr", addr, 32'h14);
      check("stall_ifid", ipc, 32'h10);
    end
    cyc(0, 32'h5555_5555, 1, 1, 32'h203);
    check("br_stall_addr", addr, 32'h200);
    check("br_stall_bubble", {31'b0, ival}, 32'h0);

    // Branch during miss: latest target wins
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
    cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h400);
    cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h500);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
    check("kill_addr_held", addr, 32'h200);
    cyc(0, 32'hDEAD_BEEF, 0, 0, 0);
    check("kill_redirect", addr, 32'h500);
    check("kill_dropped", {31'b0, ival}, 32'h0);
    cyc(0, 32'h0000_0500, 0, 0, 0);
    check("kill_next_pc", ipc, 32'h500);

    // PC wrap
    cyc(0, 32'h0, 0, 1, 32'hFFFF_FFFE);
    check("wrap_target", addr, 32'hFFFF_FFFC);
    cyc(0, 32'h1234_5678, 0, 0, 0);
    check("wrap_addr", addr, 32'h0);
    check("wrap_ifid_pc", ipc, 32'hFFFF_FFFC);

    // Counter saturation on the narrow instance
    for (int i = 0; i < 20; i++) cyc(1, 32'h0, 0, 0, 0);
    check("sat4", {28'b0, miss4}, 32'hF);
    check("miss16_total", {16'b0, miss16}, 32'd29);
    cyc(0, 32'h0, 0, 0, 0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 2,
          $urandom_range(0, 19) < 3,
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom);
    end
    reset = 1'b1;
    run(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
